// File: rtl/cfg_routing_mux_if.sv
// Configuration-chain and data-path signals of one routing multiplexer.
// master drives chain, commit and input buses; slave is the multiplexer itself.
interface cfg_routing_mux_if #(
  parameter int NUM_IN = 8,
  parameter int WIDTH  = 1
);
  localparam int SEL_W = $clog2(NUM_IN + 1);

  logic                    ccff_head;
  logic                    ccff_shift;
  logic                    ccff_tail;
  logic                    cfg_commit;
  logic                    cfg_ack;
  logic                    cfg_err;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [WIDTH-1:0]        out_data;
  logic                    out_valid;
  logic [SEL_W-1:0]        active_sel;

  modport master (
    output ccff_head, ccff_shift, cfg_commit, in_data,
    input  ccff_tail, cfg_ack, cfg_err, out_data, out_valid, active_sel
  );

  modport slave (
    input  ccff_head, ccff_shift, cfg_commit, in_data,
    output ccff_tail, cfg_ack, cfg_err, out_data, out_valid, active_sel
  );
endinterface

// File: rtl/cfg_routing_mux.sv
// Chain-programmed routing multiplexer: picks one of NUM_IN buses or drives a
// synthesizable off state (data 0, valid 0). Code 0 = off, 1..NUM_IN = bus code-1.
module cfg_routing_mux #(
  parameter int NUM_IN  = 8,
  parameter int WIDTH   = 1,
  parameter bit REG_OUT = 1'b0
) (
  input logic              prog_clk,
  input logic              prog_reset_n,
  cfg_routing_mux_if.slave bus
);
  localparam int SEL_W = $clog2(NUM_IN + 1);
  localparam int CNT_W = $clog2(SEL_W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SEL_W);
  localparam logic [SEL_W-1:0] MAX_CODE = SEL_W'(NUM_IN);

  logic [SEL_W-1:0] sr;
  logic [SEL_W-1:0] active_sel;
  logic [CNT_W-1:0] cnt;
  logic             cfg_ack;
  logic             cfg_err;
  logic             full;
  logic             accept;
  logic             sr_legal;
  logic [WIDTH-1:0] mux_data;
  logic             mux_valid;

  // Commit handshake: cfg_commit is a level request sampled each edge; it is
  // accepted only once SEL_W bits have been shifted, answered by a one-cycle
  // cfg_ack. A request seen with too few bits is dropped and flags cfg_err.
  assign full     = (cnt == CNT_FULL);
  assign accept   = bus.cfg_commit && full;
  assign sr_legal = (sr <= MAX_CODE);

  always_ff @(posedge prog_clk) begin
    if (!prog_reset_n) begin
      sr         <= '0;
      cnt        <= '0;
      active_sel <= '0;
      cfg_ack    <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      if (bus.ccff_shift) sr <= {sr[SEL_W-2:0], bus.ccff_head};
      if (accept) begin
        active_sel <= sr;
        cfg_ack    <= 1'b1;
        cfg_err    <= !sr_legal;
        cnt        <= bus.ccff_shift ? CNT_W'(1) : '0;
      end else begin
        cfg_ack <= 1'b0;
        if (bus.cfg_commit) cfg_err <= 1'b1;
        if (bus.ccff_shift && !full) cnt <= cnt + 1'b1;
      end
    end
  end

  // Illegal codes match no bus and therefore fall through to the off state.
  always_comb begin
    mux_data  = '0;
    mux_valid = 1'b0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (active_sel == SEL_W'(k + 1)) begin
        mux_data  = bus.in_data[k*WIDTH +: WIDTH];
        mux_valid = 1'b1;
      end
    end
  end

  generate
    if (REG_OUT) begin : g_reg_out
      logic [WIDTH-1:0] data_q;
      logic             valid_q;
      always_ff @(posedge prog_clk) begin
        if (!prog_reset_n) begin
          data_q  <= '0;
          valid_q <= 1'b0;
        end else begin
          data_q  <= mux_data;
          valid_q <= mux_valid;
        end
      end
      assign bus.out_data  = data_q;
      assign bus.out_valid = valid_q;
    end else begin : g_comb_out
      assign bus.out_data  = mux_data;
      assign bus.out_valid = mux_valid;
    end
  endgenerate

  assign bus.ccff_tail  = sr[SEL_W-1];
  assign bus.cfg_ack    = cfg_ack;
  assign bus.cfg_err    = cfg_err;
  assign bus.active_sel = active_sel;
endmodule

// File: tb/tb_cfg_routing_mux.sv
// Directed bench for cfg_routing_mux: one combinational-output and one
// registered-output instance share the same chain and data stimulus.
module tb_cfg_routing_mux;
  localparam int NUM_IN = 8;
  localparam int WIDTH  = 4;

  logic        clk;
  logic        rst_n;
  logic        head;
  logic        shift;
  logic        commit;
  logic [31:0] in_data;

  int n_pass  = 0;
  int n_total = 0;

  logic [3:0]  m_sr;
  logic [10:0] exp_q[$];
  logic [4:0]  exp_r_q[$];

  cfg_routing_mux_if #(.NUM_IN(NUM_IN), .WIDTH(WIDTH)) bus0 ();
  cfg_routing_mux_if #(.NUM_IN(NUM_IN), .WIDTH(WIDTH)) bus1 ();

  assign bus0.ccff_head  = head;
  assign bus0.ccff_shift = shift;
  assign bus0.cfg_commit = commit;
  assign bus0.in_data    = in_data;
  assign bus1.ccff_head  = head;
  assign bus1.ccff_shift = shift;
  assign bus1.cfg_commit = commit;
  assign bus1.in_data    = in_data;

  cfg_routing_mux #(.NUM_IN(NUM_IN), .WIDTH(WIDTH), .REG_OUT(1'b0)) dut0 (
    .prog_clk(clk), .prog_reset_n(rst_n), .bus(bus0)
  );
  cfg_routing_mux #(.NUM_IN(NUM_IN), .WIDTH(WIDTH), .REG_OUT(1'b1)) dut1 (
    .prog_clk(clk), .prog_reset_n(rst_n), .bus(bus1)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {valid, data} the selected code should produce with the current in_data
  function automatic logic [4:0] decode(input logic [3:0] code);
    logic [31:0] d;
    int idx;
    d = in_data;
    if (code == 4'd0 || code > 4'd8) return 5'd0;
    idx = int'(code) - 1;
    return {1'b1, d[idx*4 +: 4]};
  endfunction

  // driver tasks
  task automatic shift_bit(input logic b);
    head  = b;
    shift = 1'b1;
    tick();
    shift = 1'b0;
    m_sr  = {m_sr[2:0], b};
    check("ccff_tail", 32'(bus0.ccff_tail), 32'(m_sr[3]));
  endtask

  task automatic shift_code(input logic [3:0] code);
    for (int i = 3; i >= 0; i--) shift_bit(code[i]);
  endtask

  task automatic check_main();
    check("exp_q_nonempty", 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0)
      check("dut0_ack_err_valid_sel_data",
            32'({bus0.cfg_ack, bus0.cfg_err, bus0.out_valid, bus0.active_sel, bus0.out_data}),
            32'(exp_q.pop_front()));
  endtask

  task automatic check_reg();
    check("exp_r_q_nonempty", 32'(exp_r_q.size() != 0), 32'd1);
    if (exp_r_q.size() != 0)
      check("dut1_valid_data", 32'({bus1.out_valid, bus1.out_data}), 32'(exp_r_q.pop_front()));
  endtask

  // Commit request, optionally with a simultaneous shift of bit b.
  task automatic do_commit(input logic with_shift, input logic b, input logic e_ack,
                           input logic e_err, input logic [3:0] e_sel);
    logic [4:0] vd;
    vd = decode(e_sel);
    exp_q.push_back({e_ack, e_err, vd[4], e_sel, vd[3:0]});
    exp_r_q.push_back(vd);
    commit = 1'b1;
    shift  = with_shift;
    head   = b;
    tick();
    commit = 1'b0;
    shift  = 1'b0;
    if (with_shift) m_sr = {m_sr[2:0], b};
    check_main();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sel"},   32'(bus0.active_sel), 32'd0);
    check({tag, "_data"},  32'(bus0.out_data),   32'd0);
    check({tag, "_valid"}, 32'(bus0.out_valid),  32'd0);
    check({tag, "_err"},   32'(bus0.cfg_err),    32'd0);
    check({tag, "_tail"},  32'(bus0.ccff_tail),  32'd0);
    check({tag, "_ack"},   32'(bus0.cfg_ack),    32'd0);
    check({tag, "_r_out"}, 32'({bus1.out_valid, bus1.out_data}), 32'd0);
  endtask

  initial begin
    rst_n   = 1'b0;
    head    = 1'b0;
    shift   = 1'b0;
    commit  = 1'b0;
    m_sr    = 4'd0;
    in_data = $urandom;
    in_data[11:8] = 4'hA;

    // reset
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check_all_zero("reset");

    // code 3 -> bus2 = A
    shift_code(4'h3);
    do_commit(1'b0, 1'b0, 1'b1, 1'b0, 4'd3);
    tick();
    check_reg();
    check("ack_pulse_drop", 32'(bus0.cfg_ack), 32'd0);

    // short shift rejected, then code 8 -> bus7
    shift_bit(1'b1);
    shift_bit(1'b0);
    do_commit(1'b0, 1'b0, 1'b0, 1'b1, 4'd3);
    tick();
    check_reg();
    shift_code(4'h8);
    do_commit(1'b0, 1'b0, 1'b1, 1'b0, 4'd8);
    tick();
    check_reg();

    // illegal code 15: stored, off, error; tail replays previous code 1000
    shift_code(4'hF);
    do_commit(1'b0, 1'b0, 1'b1, 1'b1, 4'd15);
    tick();
    check_reg();

    // commit with simultaneous shift takes pre-shift code; next commit rejected
    shift_code(4'h5);
    do_commit(1'b1, 1'b1, 1'b1, 1'b0, 4'd5);
    do_commit(1'b0, 1'b0, 1'b0, 1'b1, 4'd5);
    check_reg();
    tick();
    check_reg();

    // reset mid-shift with code 5 active
    shift_bit(1'b1);
    shift_bit(1'b0);
    rst_n = 1'b0;
    tick();
    m_sr = 4'd0;
    check_all_zero("midreset");
    rst_n = 1'b1;
    do_commit(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    tick();
    check_reg();

    // over-shift: last four bits (0010) retained, legal commit clears error
    shift_bit(1'b1);
    shift_bit(1'b1);
    shift_code(4'h2);
    do_commit(1'b0, 1'b0, 1'b1, 1'b0, 4'd2);
    tick();
    check_reg();

    // combinational data path follows in_data for the selected bus1
    for (int i = 0; i < 4; i++) begin
      in_data = $urandom;
      #1;
      check("comb_data", 32'({bus0.out_valid, bus0.out_data}), 32'({1'b1, in_data[7:4]}));
    end

    // explicit off code
    shift_code(4'h0);
    do_commit(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    tick();
    check_reg();

    // report
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
